// File: rtl/yazmac_obegi_skor.sv
// Register file with a busy scoreboard for operand stall detection.
// Optional same-cycle write-back forwarding is enabled by defining YAZMAC_BYPASS_EN.
module yazmac_obegi_skor #(
   parameter int VERI_BIT    = 32,
   parameter int YAZMAC_SAYI = 32
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [4:0]          cyo_yaz_adres_i,
   input  logic [VERI_BIT-1:0] cyo_yaz_deger_i,
   input  logic                cyo_yaz_yazmac_i,
   input  logic [4:0]          coz_rs1_adres_i,
   input  logic [4:0]          coz_rs2_adres_i,
   output logic [VERI_BIT-1:0] coz_rs1_deger_o,
   output logic [VERI_BIT-1:0] coz_rs2_deger_o,
   input  logic                coz_rezerve_i,
   input  logic [4:0]          coz_rd_adres_i,
   input  logic                coz_temizle_i,
   output logic                coz_dur_o
);

   logic [VERI_BIT-1:0] yazmac_q [YAZMAC_SAYI];
   logic [31:0]         mesgul_q;
   logic [31:0]         mesgul_d;

   logic                yaz_gecerli;
   logic [31:0]         atla_maske;
   logic [31:0]         mesgul_etkin;
   logic [31:0]         sil_maske;
   logic [31:0]         ayir_maske;
   logic [VERI_BIT-1:0] rs1_deger;
   logic [VERI_BIT-1:0] rs2_deger;
   logic                dur;

   // Write qualification, forwarding mask and effective busy view
   always_comb begin
      yaz_gecerli = cyo_yaz_yazmac_i && (cyo_yaz_adres_i != 5'd0);
      atla_maske  = 32'd0;
`ifdef YAZMAC_BYPASS_EN
      atla_maske  = yaz_gecerli ? (32'd1 << cyo_yaz_adres_i) : 32'd0;
`endif
      mesgul_etkin = mesgul_q & ~atla_maske;
   end

   // Combinational read ports, forced to zero while in reset
   always_comb begin
      rs1_deger = '0;
      rs2_deger = '0;
      if (!rst_i || coz_rs1_adres_i == 5'd0) begin
         rs1_deger = '0;
`ifdef YAZMAC_BYPASS_EN
      end else if (yaz_gecerli && coz_rs1_adres_i == cyo_yaz_adres_i) begin
         rs1_deger = cyo_yaz_deger_i;
`endif
      end else if (int'(coz_rs1_adres_i) < YAZMAC_SAYI) begin
         rs1_deger = yazmac_q[coz_rs1_adres_i];
      end else begin
         rs1_deger = '0;
      end
      if (!rst_i || coz_rs2_adres_i == 5'd0) begin
         rs2_deger = '0;
`ifdef YAZMAC_BYPASS_EN
      end else if (yaz_gecerli && coz_rs2_adres_i == cyo_yaz_adres_i) begin
         rs2_deger = cyo_yaz_deger_i;
`endif
      end else if (int'(coz_rs2_adres_i) < YAZMAC_SAYI) begin
         rs2_deger = yazmac_q[coz_rs2_adres_i];
      end else begin
         rs2_deger = '0;
      end
   end

   // Stall detection and next busy vector; a new reservation beats a same-cycle clear, flush beats both
   always_comb begin
      dur = rst_i &&
            ((mesgul_etkin[coz_rs1_adres_i] && (coz_rs1_adres_i != 5'd0)) ||
             (mesgul_etkin[coz_rs2_adres_i] && (coz_rs2_adres_i != 5'd0)));
      sil_maske  = cyo_yaz_yazmac_i ? (32'd1 << cyo_yaz_adres_i) : 32'd0;
      ayir_maske = (coz_rezerve_i && !dur && (coz_rd_adres_i != 5'd0))
                   ? (32'd1 << coz_rd_adres_i) : 32'd0;
      mesgul_d   = coz_temizle_i ? 32'd0
                   : (((mesgul_q & ~sil_maske) | ayir_maske) & ~32'd1);
   end

   // Busy vector register
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         mesgul_q <= 32'd0;
      end else begin
         mesgul_q <= mesgul_d;
      end
   end

   // Register storage; entry 0 is never written
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < YAZMAC_SAYI; i++) begin
         if (!rst_i) begin
            yazmac_q[i] <= '0;
         end else if (yaz_gecerli && int'(cyo_yaz_adres_i) == i) begin
            yazmac_q[i] <= cyo_yaz_deger_i;
         end
      end
   end

   assign coz_rs1_deger_o = rs1_deger;
   assign coz_rs2_deger_o = rs2_deger;
   assign coz_dur_o       = dur;

endmodule

// File: tb/tb_yazmac_obegi_skor.sv
// Directed vector bench for yazmac_obegi_skor; expectations follow YAZMAC_BYPASS_EN.
module tb_yazmac_obegi_skor;

   typedef struct packed {
      logic        rst;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        we;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        rez;
      logic [4:0]  rd;
      logic        fl;
      logic [31:0] e1;
      logic [31:0] e2;
      logic        ed;
   } vek_t;

`ifdef YAZMAC_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  wa;
   logic [31:0] wd;
   logic        we;
   logic [4:0]  rs1, rs2, rd;
   logic        rez, fl;
   logic [31:0] d1, d2;
   logic        dur;

   int checks = 0;
   int errors = 0;

   yazmac_obegi_skor dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .cyo_yaz_adres_i  (wa),
      .cyo_yaz_deger_i  (wd),
      .cyo_yaz_yazmac_i (we),
      .coz_rs1_adres_i  (rs1),
      .coz_rs2_adres_i  (rs2),
      .coz_rs1_deger_o  (d1),
      .coz_rs2_deger_o  (d2),
      .coz_rezerve_i    (rez),
      .coz_rd_adres_i   (rd),
      .coz_temizle_i    (fl),
      .coz_dur_o        (dur)
   );

   always #5 clk = ~clk;

   function automatic vek_t mk(input logic r, input logic [4:0] a, input logic [31:0] d,
                               input logic w, input logic [4:0] s1, input logic [4:0] s2,
                               input logic z, input logic [4:0] t, input logic f,
                               input logic [31:0] x1, input logic [31:0] x2, input logic xd);
      vek_t v;
      v = '{rst:r, wa:a, wd:d, we:w, rs1:s1, rs2:s2, rez:z, rd:t, fl:f, e1:x1, e2:x2, ed:xd};
      return v;
   endfunction

   task automatic apply(input vek_t v, input string nm);
      @(negedge clk);
      rst = v.rst; wa = v.wa; wd = v.wd; we = v.we;
      rs1 = v.rs1; rs2 = v.rs2; rez = v.rez; rd = v.rd; fl = v.fl;
      #1;
      checks++;
      if (d1 !== v.e1) begin
         errors++;
         $display("FAIL %s rs1_deger: got %h want %h", nm, d1, v.e1);
      end
      checks++;
      if (d2 !== v.e2) begin
         errors++;
         $display("FAIL %s rs2_deger: got %h want %h", nm, d2, v.e2);
      end
      checks++;
      if (dur !== v.ed) begin
         errors++;
         $display("FAIL %s dur: got %b want %b", nm, dur, v.ed);
      end
   endtask

   vek_t tbl [12];

   initial begin
      rst = 1'b0; wa = 5'd0; wd = 32'd0; we = 1'b0;
      rs1 = 5'd0; rs2 = 5'd0; rez = 1'b0; rd = 5'd0; fl = 1'b0;

      //          rst   wa     wd             we    rs1    rs2    rez   rd     fl    e1             e2             ed
      tbl[0]  = mk(1'b0, 5'd5, 32'h0000_1111, 1'b1, 5'd5,  5'd0, 1'b1, 5'd6,  1'b0, 32'h0,         32'h0,         1'b0);
      tbl[1]  = mk(1'b1, 5'd0, 32'h0,         1'b0, 5'd5,  5'd6, 1'b0, 5'd0,  1'b0, 32'h0,         32'h0,         1'b0);
      tbl[2]  = mk(1'b1, 5'd5, 32'h1234_5678, 1'b1, 5'd0,  5'd0, 1'b0, 5'd0,  1'b0, 32'h0,         32'h0,         1'b0);
      tbl[3]  = mk(1'b1, 5'd0, 32'h0,         1'b0, 5'd5,  5'd0, 1'b0, 5'd0,  1'b0, 32'h1234_5678, 32'h0,         1'b0);
      tbl[4]  = mk(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0,  5'd5, 1'b1, 5'd0,  1'b0, 32'h0,         32'h1234_5678, 1'b0);
      tbl[5]  = mk(1'b1, 5'd0, 32'h0,         1'b0, 5'd0,  5'd0, 1'b0, 5'd0,  1'b0, 32'h0,         32'h0,         1'b0);
      tbl[6]  = mk(1'b1, 5'd8, 32'hDEAD_BEEF, 1'b1, 5'd5,  5'd0, 1'b1, 5'd7,  1'b0, 32'h1234_5678, 32'h0,         1'b0);
      tbl[7]  = mk(1'b1, 5'd0, 32'h0,         1'b0, 5'd8,  5'd7, 1'b0, 5'd0,  1'b0, 32'hDEAD_BEEF, 32'h0,         1'b1);
      tbl[8]  = mk(1'b1, 5'd0, 32'h0,         1'b0, 5'd8,  5'd7, 1'b1, 5'd9,  1'b0, 32'hDEAD_BEEF, 32'h0,         1'b1);
      tbl[9]  = mk(1'b1, 5'd0, 32'h0,         1'b0, 5'd9,  5'd0, 1'b0, 5'd0,  1'b0, 32'h0,         32'h0,         1'b0);
      tbl[10] = mk(1'b1, 5'd7, 32'h0000_0077, 1'b1, 5'd0,  5'd0, 1'b0, 5'd0,  1'b0, 32'h0,         32'h0,         1'b0);
      tbl[11] = mk(1'b1, 5'd0, 32'h0,         1'b0, 5'd7,  5'd7, 1'b0, 5'd0,  1'b0, 32'h77,        32'h77,        1'b0);

      for (int i = 0; i < 12; i++) begin
         apply(tbl[i], $sformatf("tbl%0d", i));
      end

      // Reserve x7, then write-back 0xA5 while rs2 reads it
      apply(mk(1'b1, 5'd0, 32'h0,  1'b0, 5'd0, 5'd0, 1'b1, 5'd7, 1'b0, 32'h0, 32'h0,  1'b0), "h_rez7");
      apply(mk(1'b1, 5'd0, 32'h0,  1'b0, 5'd0, 5'd7, 1'b0, 5'd0, 1'b0, 32'h0, 32'h77, 1'b1), "h_stall7");
      apply(mk(1'b1, 5'd7, 32'hA5, 1'b1, 5'd0, 5'd7, 1'b0, 5'd0, 1'b0, 32'h0,
               BYP ? 32'hA5 : 32'h77, BYP ? 1'b0 : 1'b1), "h_wb7");
      apply(mk(1'b1, 5'd0, 32'h0,  1'b0, 5'd0, 5'd7, 1'b0, 5'd0, 1'b0, 32'h0, 32'hA5, 1'b0), "h_after7");

      // Same-cycle reserve and write-back of x9; then a second reservation
      apply(mk(1'b1, 5'd9, 32'h99, 1'b1, 5'd0, 5'd0, 1'b1, 5'd9, 1'b0, 32'h0,  32'h0, 1'b0), "h_both9");
      apply(mk(1'b1, 5'd0, 32'h0,  1'b0, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0, 32'h99, 32'h0, 1'b1), "h_busy9");
      apply(mk(1'b1, 5'd0, 32'h0,  1'b0, 5'd0, 5'd0, 1'b1, 5'd9, 1'b0, 32'h0,  32'h0, 1'b0), "h_rerez9");
      apply(mk(1'b1, 5'd0, 32'h0,  1'b0, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0, 32'h99, 32'h0, 1'b1), "h_still9");
      apply(mk(1'b1, 5'd9, 32'h9A, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0,  32'h0, 1'b0), "h_wb9");
      apply(mk(1'b1, 5'd0, 32'h0,  1'b0, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0, 32'h9A, 32'h0, 1'b0), "h_free9");

      // Flush drops reservations of x3/x4, keeps the write, and beats a same-cycle reserve
      apply(mk(1'b1, 5'd0, 32'h0,  1'b0, 5'd0, 5'd0, 1'b1, 5'd3, 1'b0, 32'h0, 32'h0, 1'b0), "h_rez3");
      apply(mk(1'b1, 5'd0, 32'h0,  1'b0, 5'd0, 5'd0, 1'b1, 5'd4, 1'b0, 32'h0, 32'h0, 1'b0), "h_rez4");
      apply(mk(1'b1, 5'd3, 32'h33, 1'b1, 5'd3, 5'd4, 1'b0, 5'd0, 1'b1,
               BYP ? 32'h33 : 32'h0, 32'h0, 1'b1), "h_flush");
      apply(mk(1'b1, 5'd0, 32'h0,  1'b0, 5'd3, 5'd4, 1'b1, 5'd12, 1'b1, 32'h33, 32'h0, 1'b0), "h_flushrez");
      apply(mk(1'b1, 5'd0, 32'h0,  1'b0, 5'd12, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0), "h_free12");

      // Reset while x10 is busy and a write is pending
      apply(mk(1'b1, 5'd0, 32'h0,  1'b0, 5'd0,  5'd0, 1'b1, 5'd10, 1'b0, 32'h0, 32'h0, 1'b0), "h_rez10");
      apply(mk(1'b0, 5'd6, 32'h66, 1'b1, 5'd10, 5'd5, 1'b1, 5'd11, 1'b0, 32'h0, 32'h0, 1'b0), "h_inrst");
      apply(mk(1'b1, 5'd0, 32'h0,  1'b0, 5'd10, 5'd5, 1'b0, 5'd0,  1'b0, 32'h0, 32'h0, 1'b0), "h_post1");
      apply(mk(1'b1, 5'd0, 32'h0,  1'b0, 5'd6,  5'd11, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0), "h_post2");

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/yazmac_obegi_skor.md
YAZMAC_OBEGI_SKOR -- requirements
Module: yazmac_obegi_skor

Interface
REQ-001 SHALL have parameter VERI_BIT, default 32, meaning register data width.
REQ-002 SHALL have parameter YAZMAC_SAYI, default 32, meaning architectural register count; address width is 5.
REQ-003 SHALL have port clk_i, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, meaning reset, synchronous, active-low.
REQ-005 SHALL have port cyo_yaz_adres_i, input, 5, meaning write-back destination address from the write-back stage.
REQ-006 SHALL have port cyo_yaz_deger_i, input, VERI_BIT, meaning write-back data.
REQ-007 SHALL have port cyo_yaz_yazmac_i, input, 1, meaning write-back enable.
REQ-008 SHALL have ports coz_rs1_adres_i and coz_rs2_adres_i, input, 5 each, meaning decode read addresses.
REQ-009 SHALL have ports coz_rs1_deger_o and coz_rs2_deger_o, output, VERI_BIT each, meaning read data (combinational from address).
REQ-010 SHALL have port coz_rezerve_i, input, 1, meaning decode issues an instruction that will write coz_rd_adres_i.
REQ-011 SHALL have port coz_rd_adres_i, input, 5, meaning destination being reserved.
REQ-012 SHALL have port coz_temizle_i, input, 1, meaning pipeline flush; drops all reservations.
REQ-013 SHALL have port coz_dur_o, output, 1, meaning stall: a read operand has a pending write.

Function
REQ-014 SHALL hold YAZMAC_SAYI registers; x0 reads 0, writes to x0 ignored.
REQ-015 SHALL write cyo_yaz_deger_i into register cyo_yaz_adres_i on the clock edge when cyo_yaz_yazmac_i=1 and address != 0.
REQ-016 SHALL keep a 32-bit busy vector; bit 0 constantly 0.
REQ-017 SHALL set busy[coz_rd_adres_i] on the edge when coz_rezerve_i=1, coz_dur_o=0 and address != 0.
REQ-018 SHALL clear busy[cyo_yaz_adres_i] on the edge when cyo_yaz_yazmac_i=1.
REQ-019 SHALL, when set and clear target the same address in one cycle, leave the bit set (newer reservation wins).
REQ-020 SHALL, when coz_temizle_i=1, clear all busy bits on that edge, overriding any set in the same cycle; register writes that cycle still occur.
REQ-021 SHALL drive coz_dur_o = (busy[rs1] and rs1 != 0) or (busy[rs2] and rs2 != 0), with the effective busy value after same-cycle bypass per REQ-027.
REQ-022 SHALL ignore coz_rezerve_i while coz_dur_o=1 (no reservation from a stalled instruction).
REQ-023 SHALL not count reservations; a second reservation of a busy address keeps it busy until the next write-back to that address.
REQ-024 SHALL have read latency 0 (combinational) and write latency 1 (visible on the cycle after the edge, or same cycle with bypass).

Reset
REQ-025 SHALL, on the edge with rst_i=0, clear all registers to 0 and all busy bits to 0; resets mid-operation discard the pending write and reservation of that cycle.
REQ-026 SHALL hold coz_dur_o=0 and both read outputs 0 while rst_i=0.

Configuration
REQ-027 SHALL, with macro YAZMAC_BYPASS_EN defined, forward cyo_yaz_deger_i to a read port whose address equals cyo_yaz_adres_i (non-zero, enable=1) in the same cycle, and treat that address as not busy for coz_dur_o that cycle; without the macro, reads return stored values only and the stall persists until the cycle after write-back.

Verification
REQ-028 SHALL verify: reset, write x5=0x1234_5678, next cycle read rs1=5 -> 0x1234_5678, dur=0.
REQ-029 SHALL verify: write x0=0xFFFF_FFFF -> rs1=0 reads 0, busy[0] never set.
REQ-030 SHALL verify: reserve x7, next cycle rs2=7 -> dur=1; write-back x7=0xA5 -> with YAZMAC_BYPASS_EN, same-cycle read 0xA5 and dur=0; without it, dur=0 and 0xA5 one cycle later.
REQ-031 SHALL verify: same-cycle reserve x9 and write-back x9 -> busy[9]=1 afterwards, dur=1 for rs1=9.
REQ-032 SHALL verify: reserve x3 and x4, assert coz_temizle_i -> next cycle dur=0 for rs1=3, rs2=4.
REQ-033 SHALL verify: busy x10, rst_i=0 for one edge -> all reads 0, dur=0 after release.
